// File: rtl/datamem_dma.sv
// Block-transfer engine for the single-port datamem: word copy with memmove
// ordering, or constant fill, mastering the memory port while busy.
module datamem_dma #(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          mode,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW-1:0] len,
   input  logic [DW-1:0] fill_value,
   output logic [AW-1:0] mem_address,
   output logic          mem_read_enable,
   output logic          mem_write_enable,
   output logic [DW-1:0] mem_write_data,
   input  logic [DW-1:0] mem_read_data,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] remaining
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_FILL,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_srcPtr;
   logic [AW-1:0] r_dstPtr;
   logic [AW-1:0] r_remaining;
   logic [DW-1:0] r_hold;
   logic [DW-1:0] r_fill;
   logic          r_desc;

   logic [AW-1:0] w_span;
   logic [AW-1:0] w_lenM1;
   logic [AW-1:0] w_step;
   logic          w_desc;

   // A copy whose destination overlaps the tail of its source must run
   // backwards so no source word is overwritten before it has been read.
   assign w_span  = dst - src;
   assign w_lenM1 = len - AW'(1);
   assign w_desc  = !mode && (dst > src) && (w_span < len);
   assign w_step  = r_desc ? '1 : AW'(1);

   assign remaining = r_remaining;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next           = r_state;
      mem_address      = '0;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      mem_write_data   = '0;
      busy             = 1'b0;
      done             = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  w_next = S_DONE;
               end else if (mode) begin
                  w_next = S_FILL;
               end else begin
                  w_next = S_READ;
               end
            end
         end
         S_READ: begin
            mem_address     = r_srcPtr;
            mem_read_enable = 1'b1;
            busy            = 1'b1;
            w_next          = S_WRITE;
         end
         S_WRITE: begin
            mem_address      = r_dstPtr;
            mem_write_enable = 1'b1;
            mem_write_data   = r_hold;
            busy             = 1'b1;
            w_next           = (r_remaining == AW'(1)) ? S_DONE : S_READ;
         end
         S_FILL: begin
            mem_address      = r_dstPtr;
            mem_write_enable = 1'b1;
            mem_write_data   = r_fill;
            busy             = 1'b1;
            w_next           = (r_remaining == AW'(1)) ? S_DONE : S_FILL;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_srcPtr    <= '0;
         r_dstPtr    <= '0;
         r_remaining <= '0;
         r_hold      <= '0;
         r_fill      <= '0;
         r_desc      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_srcPtr    <= w_desc ? src + w_lenM1 : src;
                  r_dstPtr    <= w_desc ? dst + w_lenM1 : dst;
                  r_remaining <= len;
                  r_fill      <= fill_value;
                  r_desc      <= w_desc;
               end
            end
            S_READ: begin
               r_hold <= mem_read_data;
            end
            S_WRITE: begin
               r_srcPtr    <= r_srcPtr + w_step;
               r_dstPtr    <= r_dstPtr + w_step;
               r_remaining <= r_remaining - AW'(1);
            end
            S_FILL: begin
               r_dstPtr    <= r_dstPtr + w_step;
               r_remaining <= r_remaining - AW'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_datamem_dma.sv
// Self-checking bench for datamem_dma: a behavioural datamem, a scoreboard of
// expected writes built from a memory snapshot, and one task per scenario.
module tb_datamem_dma;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
   } wr_t;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        mode;
   logic [15:0] src;
   logic [15:0] dst;
   logic [15:0] len;
   logic [15:0] fill_value;
   logic [15:0] mem_address;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic [15:0] mem_write_data;
   logic [15:0] mem_read_data;
   logic        busy;
   logic        done;
   logic [15:0] remaining;

   logic [15:0] mem [0:65535];
   logic        plEn;
   logic [15:0] plAddr;
   logic [15:0] plData;

   int total;
   int bad;

   wr_t expQ[$];
   wr_t obsQ[$];
   int  busyCnt;
   int  doneCyc;
   int  rdCnt;
   int  protoErr;
   int  altErr;
   logic [15:0] firstRem;
   logic [15:0] doneRem;

   int          pokeCyc;
   logic        pokeMode;
   logic [15:0] pokeSrc;
   logic [15:0] pokeDst;
   logic [15:0] pokeLen;
   logic [15:0] pokeFill;

   datamem_dma #(.AW(16), .DW(16)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .mode             (mode),
      .src              (src),
      .dst              (dst),
      .len              (len),
      .fill_value       (fill_value),
      .mem_address      (mem_address),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data),
      .busy             (busy),
      .done             (done),
      .remaining        (remaining)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Combinational-read, clocked-write memory; the preload port lets the
   // bench seed contents while the engine is idle.
   assign mem_read_data = mem_read_enable ? mem[mem_address] : 16'h0000;

   always @(posedge clk) begin
      if (mem_write_enable) begin
         mem[mem_address] <= mem_write_data;
      end else if (plEn) begin
         mem[plAddr] <= plData;
      end
   end

   task automatic preload(input logic [15:0] addr, input logic [15:0] data);
      plEn   = 1'b1;
      plAddr = addr;
      plData = data;
      @(posedge clk);
      #1;
      plEn = 1'b0;
   endtask

   task automatic pushCopyExpect(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
      logic desc;
      int   k;
      desc = (d > s) && (16'(d - s) < l);
      for (int i = 0; i < int'(l); i++) begin
         k = desc ? int'(l) - 1 - i : i;
         expQ.push_back({16'(d + 16'(k)), mem[16'(s + 16'(k))]});
      end
   endtask

   task automatic pushFillExpect(input logic [15:0] d, input logic [15:0] l, input logic [15:0] v);
      for (int i = 0; i < int'(l); i++) begin
         expQ.push_back({16'(d + 16'(i)), v});
      end
   endtask

   // Issues one request and records what the port does until done (or the
   // cycle budget runs out); cycle 1 is the cycle after start is sampled.
   task automatic runTransfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                              input logic [15:0] l, input logic [15:0] f, input int maxCyc);
      logic lastWasRead;
      obsQ.delete();
      busyCnt     = 0;
      doneCyc     = -1;
      rdCnt       = 0;
      protoErr    = 0;
      altErr      = 0;
      firstRem    = 16'hxxxx;
      doneRem     = 16'hxxxx;
      lastWasRead = 1'b0;
      @(posedge clk);
      #1;
      start      = 1'b1;
      mode       = m;
      src        = s;
      dst        = d;
      len        = l;
      fill_value = f;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= maxCyc; c++) begin
         if (c == pokeCyc) begin
            start      = 1'b1;
            mode       = pokeMode;
            src        = pokeSrc;
            dst        = pokeDst;
            len        = pokeLen;
            fill_value = pokeFill;
         end else begin
            start = 1'b0;
         end
         if (c == 1) firstRem = remaining;
         if (busy) busyCnt++;
         if (mem_read_enable && mem_write_enable) protoErr++;
         if (!mem_read_enable && !mem_write_enable && mem_address != 16'h0000) protoErr++;
         if (!mem_write_enable && mem_write_data != 16'h0000) protoErr++;
         if (mem_read_enable) begin
            rdCnt++;
            if (lastWasRead) altErr++;
            lastWasRead = 1'b1;
         end
         if (mem_write_enable) begin
            obsQ.push_back({mem_address, mem_write_data});
            if (!m && !lastWasRead) altErr++;
            lastWasRead = 1'b0;
         end
         if (done) begin
            doneCyc = c;
            doneRem = remaining;
            break;
         end
         @(posedge clk);
         #1;
      end
      start   = 1'b0;
      pokeCyc = 0;
   endtask

   task automatic test_reset;
      wr_t unusedW;
      unusedW = '0;
      #2;
      total++;
      if ({busy, done, remaining, mem_address, mem_read_enable, mem_write_enable, mem_write_data} !== 52'd0) begin
         bad++;
         $display("[TB] FAIL reset_during: got busy=%b done=%b rem=%h addr=%h re=%b we=%b wd=%h expected all 0",
                  busy, done, remaining, mem_address, mem_read_enable, mem_write_enable, mem_write_data);
      end
      repeat (2) @(posedge clk);
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({busy, done, remaining, mem_address, mem_read_enable, mem_write_enable, mem_write_data} !== 52'd0) begin
         bad++;
         $display("[TB] FAIL reset_after: got busy=%b done=%b rem=%h addr=%h expected all 0",
                  busy, done, remaining, mem_address);
      end
      expQ.push_back(unusedW);
      expQ.delete();
   endtask

   task automatic test_fill;
      wr_t e, o;
      preload(16'h0104, 16'h1234);
      pushFillExpect(16'h0100, 16'd4, 16'hBEEF);
      runTransfer(1'b1, 16'h0000, 16'h0100, 16'd4, 16'hBEEF, 40);
      total++;
      if (busyCnt !== 4) begin bad++; $display("[TB] FAIL fill_busy: got %0d expected 4", busyCnt); end
      total++;
      if (doneCyc !== 5) begin bad++; $display("[TB] FAIL fill_done_cycle: got %0d expected 5", doneCyc); end
      total++;
      if (firstRem !== 16'd4) begin bad++; $display("[TB] FAIL fill_remaining_load: got %0d expected 4", firstRem); end
      total++;
      if (doneRem !== 16'd0) begin bad++; $display("[TB] FAIL fill_remaining_done: got %0d expected 0", doneRem); end
      total++;
      if (protoErr !== 0) begin bad++; $display("[TB] FAIL fill_port_rules: got %0d violations expected 0", protoErr); end
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if (obsQ.size() == 0) begin
            bad++; $display("[TB] FAIL fill_write: got none expected %h@%h", e.d, e.a);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin bad++; $display("[TB] FAIL fill_write: got %h@%h expected %h@%h", o.d, o.a, e.d, e.a); end
         end
      end
      total++;
      if (obsQ.size() !== 0) begin bad++; $display("[TB] FAIL fill_extra_writes: got %0d expected 0", obsQ.size()); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem[16'h0100 + 16'(i)] !== 16'hBEEF) begin
            bad++; $display("[TB] FAIL fill_mem: got %h expected beef", mem[16'h0100 + 16'(i)]);
         end
      end
      total++;
      if (mem[16'h0104] !== 16'h1234) begin bad++; $display("[TB] FAIL fill_guard_word: got %h expected 1234", mem[16'h0104]); end
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0) begin bad++; $display("[TB] FAIL fill_done_pulse_width: got %b expected 0", done); end
   endtask

   task automatic test_copy_ascending;
      wr_t e, o;
      for (int i = 0; i < 3; i++) preload(16'h0010 + 16'(i), 16'(i + 1));
      pushCopyExpect(16'h0010, 16'h0020, 16'd3);
      runTransfer(1'b0, 16'h0010, 16'h0020, 16'd3, 16'h0000, 40);
      total++;
      if (busyCnt !== 6) begin bad++; $display("[TB] FAIL asc_busy: got %0d expected 6", busyCnt); end
      total++;
      if (doneCyc !== 7) begin bad++; $display("[TB] FAIL asc_done_cycle: got %0d expected 7", doneCyc); end
      total++;
      if (rdCnt !== 3 || altErr !== 0) begin bad++; $display("[TB] FAIL asc_alternation: got reads=%0d alt_err=%0d expected 3/0", rdCnt, altErr); end
      total++;
      if (protoErr !== 0) begin bad++; $display("[TB] FAIL asc_port_rules: got %0d expected 0", protoErr); end
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if (obsQ.size() == 0) begin
            bad++; $display("[TB] FAIL asc_write: got none expected %h@%h", e.d, e.a);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin bad++; $display("[TB] FAIL asc_write: got %h@%h expected %h@%h", o.d, o.a, e.d, e.a); end
         end
      end
      total++;
      if (obsQ.size() !== 0) begin bad++; $display("[TB] FAIL asc_extra_writes: got %0d expected 0", obsQ.size()); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (mem[16'h0020 + 16'(i)] !== 16'(i + 1)) begin
            bad++; $display("[TB] FAIL asc_mem: got %h expected %h", mem[16'h0020 + 16'(i)], 16'(i + 1));
         end
      end
   endtask

   task automatic test_copy_overlap;
      wr_t e, o;
      logic [15:0] vals [4];
      vals = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
      for (int i = 0; i < 4; i++) preload(16'h0010 + 16'(i), vals[i]);
      pushCopyExpect(16'h0010, 16'h0012, 16'd4);
      runTransfer(1'b0, 16'h0010, 16'h0012, 16'd4, 16'h0000, 40);
      total++;
      if (obsQ.size() == 0 || obsQ[0].a !== 16'h0015) begin
         bad++; $display("[TB] FAIL ovl_first_addr: got %h expected 0015", (obsQ.size() == 0) ? 16'hxxxx : obsQ[0].a);
      end
      total++;
      if (doneCyc !== 9) begin bad++; $display("[TB] FAIL ovl_done_cycle: got %0d expected 9", doneCyc); end
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if (obsQ.size() == 0) begin
            bad++; $display("[TB] FAIL ovl_write: got none expected %h@%h", e.d, e.a);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin bad++; $display("[TB] FAIL ovl_write: got %h@%h expected %h@%h", o.d, o.a, e.d, e.a); end
         end
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem[16'h0012 + 16'(i)] !== vals[i]) begin
            bad++; $display("[TB] FAIL ovl_mem: got %h expected %h", mem[16'h0012 + 16'(i)], vals[i]);
         end
      end
      total++;
      if (mem[16'h0010] !== vals[0] || mem[16'h0011] !== vals[1]) begin
         bad++; $display("[TB] FAIL ovl_src_head: got %h %h expected %h %h", mem[16'h0010], mem[16'h0011], vals[0], vals[1]);
      end
   endtask

   task automatic test_wrap_zero;
      wr_t e, o;
      pushFillExpect(16'hFFFE, 16'd3, 16'h5555);
      runTransfer(1'b1, 16'h0000, 16'hFFFE, 16'd3, 16'h5555, 40);
      total++;
      if (doneCyc !== 4) begin bad++; $display("[TB] FAIL wrap_done_cycle: got %0d expected 4", doneCyc); end
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if (obsQ.size() == 0) begin
            bad++; $display("[TB] FAIL wrap_write: got none expected %h@%h", e.d, e.a);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin bad++; $display("[TB] FAIL wrap_write: got %h@%h expected %h@%h", o.d, o.a, e.d, e.a); end
         end
      end
      total++;
      if (mem[16'hFFFE] !== 16'h5555 || mem[16'hFFFF] !== 16'h5555 || mem[16'h0000] !== 16'h5555) begin
         bad++; $display("[TB] FAIL wrap_mem: got %h %h %h expected 5555", mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000]);
      end
      runTransfer(1'b0, 16'h0030, 16'h0040, 16'd0, 16'h0000, 10);
      total++;
      if (doneCyc !== 1) begin bad++; $display("[TB] FAIL zero_done_cycle: got %0d expected 1", doneCyc); end
      total++;
      if (busyCnt !== 0 || rdCnt !== 0 || obsQ.size() !== 0) begin
         bad++; $display("[TB] FAIL zero_no_access: got busy=%0d reads=%0d writes=%0d expected 0", busyCnt, rdCnt, obsQ.size());
      end
   endtask

   task automatic test_reset_mid;
      wr_t e, o;
      int  wc;
      for (int i = 0; i < 8; i++) begin
         preload(16'h0200 + 16'(i), 16'h1000 + 16'(i));
         preload(16'h0300 + 16'(i), 16'hEEEE);
      end
      @(posedge clk);
      #1;
      start = 1'b1; mode = 1'b0; src = 16'h0200; dst = 16'h0300; len = 16'd8; fill_value = 16'h0000;
      @(posedge clk);
      #1;
      start = 1'b0;
      wc = 0;
      for (int c = 1; c <= 40; c++) begin
         if (mem_write_enable) wc++;
         if (wc == 3) break;
         @(posedge clk);
         #1;
      end
      total++;
      if (wc !== 3) begin bad++; $display("[TB] FAIL rst_mid_reach_third_write: got %0d expected 3", wc); end
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if ({busy, done, remaining, mem_address, mem_read_enable, mem_write_enable, mem_write_data} !== 52'd0) begin
         bad++; $display("[TB] FAIL rst_mid_outputs: got busy=%b rem=%h addr=%h re=%b we=%b expected all 0",
                         busy, remaining, mem_address, mem_read_enable, mem_write_enable);
      end
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (mem[16'h0300 + 16'(i)] !== ((i < 3) ? 16'h1000 + 16'(i) : 16'hEEEE)) begin
            bad++; $display("[TB] FAIL rst_mid_dst_word%0d: got %h", i, mem[16'h0300 + 16'(i)]);
         end
      end
      pushCopyExpect(16'h0200, 16'h0308, 16'd2);
      runTransfer(1'b0, 16'h0200, 16'h0308, 16'd2, 16'h0000, 40);
      total++;
      if (doneCyc !== 5) begin bad++; $display("[TB] FAIL rst_restart_done_cycle: got %0d expected 5", doneCyc); end
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if (obsQ.size() == 0) begin
            bad++; $display("[TB] FAIL rst_restart_write: got none expected %h@%h", e.d, e.a);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin bad++; $display("[TB] FAIL rst_restart_write: got %h@%h expected %h@%h", o.d, o.a, e.d, e.a); end
         end
      end
   endtask

   task automatic test_ignored_start;
      wr_t e, o;
      int  lateBusy;
      preload(16'h0400, 16'h4A4A);
      preload(16'h0401, 16'h4B4B);
      preload(16'h0412, 16'h7777);
      pushCopyExpect(16'h0400, 16'h0410, 16'd2);
      pokeCyc  = 2;
      pokeMode = 1'b1;
      pokeSrc  = 16'h0000;
      pokeDst  = 16'h0410;
      pokeLen  = 16'd5;
      pokeFill = 16'hDEAD;
      runTransfer(1'b0, 16'h0400, 16'h0410, 16'd2, 16'h0000, 40);
      total++;
      if (busyCnt !== 4 || doneCyc !== 5) begin
         bad++; $display("[TB] FAIL ign_timing: got busy=%0d done=%0d expected 4/5", busyCnt, doneCyc);
      end
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if (obsQ.size() == 0) begin
            bad++; $display("[TB] FAIL ign_write: got none expected %h@%h", e.d, e.a);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin bad++; $display("[TB] FAIL ign_write: got %h@%h expected %h@%h", o.d, o.a, e.d, e.a); end
         end
      end
      lateBusy = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (busy || done || mem_write_enable) lateBusy++;
      end
      total++;
      if (lateBusy !== 0) begin bad++; $display("[TB] FAIL ign_no_second_transfer: got %0d active cycles expected 0", lateBusy); end
      total++;
      if (mem[16'h0412] !== 16'h7777) begin bad++; $display("[TB] FAIL ign_guard_word: got %h expected 7777", mem[16'h0412]); end
   endtask

   task automatic test_back_to_back;
      wr_t e, o;
      int  firstDone;
      pushFillExpect(16'h0500, 16'd2, 16'h1111);
      runTransfer(1'b1, 16'h0000, 16'h0500, 16'd2, 16'h1111, 40);
      firstDone = doneCyc;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if (obsQ.size() == 0) begin
            bad++; $display("[TB] FAIL b2b_fill_write: got none expected %h@%h", e.d, e.a);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin bad++; $display("[TB] FAIL b2b_fill_write: got %h@%h expected %h@%h", o.d, o.a, e.d, e.a); end
         end
      end
      pushCopyExpect(16'h0500, 16'h0600, 16'd2);
      runTransfer(1'b0, 16'h0500, 16'h0600, 16'd2, 16'h0000, 40);
      total++;
      if (firstDone !== 3 || doneCyc !== 5) begin
         bad++; $display("[TB] FAIL b2b_done_cycles: got %0d/%0d expected 3/5", firstDone, doneCyc);
      end
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         total++;
         if (obsQ.size() == 0) begin
            bad++; $display("[TB] FAIL b2b_copy_write: got none expected %h@%h", e.d, e.a);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin bad++; $display("[TB] FAIL b2b_copy_write: got %h@%h expected %h@%h", o.d, o.a, e.d, e.a); end
         end
      end
      total++;
      if (mem[16'h0600] !== 16'h1111 || mem[16'h0601] !== 16'h1111) begin
         bad++; $display("[TB] FAIL b2b_mem: got %h %h expected 1111", mem[16'h0600], mem[16'h0601]);
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset_n    = 1'b0;
      start      = 1'b0;
      mode       = 1'b0;
      src        = 16'h0000;
      dst        = 16'h0000;
      len        = 16'h0000;
      fill_value = 16'h0000;
      plEn       = 1'b0;
      plAddr     = 16'h0000;
      plData     = 16'h0000;
      pokeCyc    = 0;
      pokeMode   = 1'b0;
      pokeSrc    = 16'h0000;
      pokeDst    = 16'h0000;
      pokeLen    = 16'h0000;
      pokeFill   = 16'h0000;
      test_reset;
      test_fill;
      test_copy_ascending;
      test_copy_overlap;
      test_wrap_zero;
      test_reset_mid;
      test_ignored_start;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
